spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, sclk half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  transfer request, sampled on the clk rising edge.
REQ-005 SHALL have port mode  input  2  SPI mode; mode[1]=CPOL, mode[0]=CPHA.
REQ-006 SHALL have port tx_data  input  8  byte to send, MSB first.
REQ-007 SHALL have port miso  input  1  serial data from slave.
REQ-008 SHALL have port sclk  output  1  SPI serial clock.
REQ-009 SHALL have port mosi  output  1  serial data to slave.
REQ-010 SHALL have port cs  output  1  slave select, active-low.
REQ-011 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-013 SHALL have port rx_data  output  8  last received byte, MSB first.

Function
REQ-014 SHALL register every output; no output is combinational from an input.
REQ-015 SHALL use an FSM with states IDLE, SETUP, TRANSFER and HOLD.
REQ-016 IDLE: SHALL drive cs=1 and busy=0, and SHALL load sclk from mode[1] on every clk edge.
REQ-017 SHALL accept start only when state is IDLE (busy=0), including the cycle in which done is high.
REQ-018 On the accepting edge, SHALL latch tx_data and mode, set cs=0 and busy=1, and enter SETUP.
REQ-019 SHALL ignore start while busy=1; tx_data and mode changes during a transfer SHALL have no effect.
REQ-020 SETUP: SHALL last CLK_DIV cycles with sclk at CPOL, then enter TRANSFER.
REQ-021 SETUP with CPHA=0: SHALL drive mosi=tx[7] on the accepting edge.
REQ-022 TRANSFER: SHALL toggle sclk every CLK_DIV cycles for exactly 16 toggles; toggle 1 occurs CLK_DIV edges after the accepting edge.
REQ-023 CPHA=0: leading (odd) toggles SHALL sample miso into the shift register LSB; trailing (even) toggles 2..14 SHALL shift the next bit onto mosi.
REQ-024 CPHA=1: leading (odd) toggles SHALL drive the next bit (tx[7] first) onto mosi; trailing (even) toggles SHALL sample miso.
REQ-025 Sampling SHALL use the miso value present at the clk edge that performs the sclk toggle.
REQ-026 After toggle 16, sclk SHALL be back at CPOL and the block SHALL enter HOLD for CLK_DIV cycles.
REQ-027 HOLD exit edge, at 17*CLK_DIV edges after acceptance: SHALL set cs=1, busy=0, done=1, load rx_data with the 8 sampled bits, and return to IDLE.
REQ-028 done SHALL be high for exactly one clk cycle per completed transfer.
REQ-029 rx_data SHALL hold its value until the next completed transfer.
REQ-030 mosi SHALL hold its last driven value in IDLE.
REQ-031 The half-period counter SHALL be 8 bits wide and reload to CLK_DIV-1 at each toggle, with no drift across transfers.

Reset
REQ-032 reset=1 SHALL immediately set state=IDLE, sclk=0, mosi=0, cs=1, busy=0, done=0 and rx_data=8'h00, regardless of clk.
REQ-033 A reset during a transfer SHALL abort it without a done pulse; the first edge after reset release SHALL set sclk to mode[1].
REQ-034 A start high while reset=1 SHALL be ignored.

Verification
REQ-035 Mode 0, CLK_DIV=2, tx_data=8'hA5, slave model returning 8'h3C -> mosi bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; done exactly 34 clk edges after acceptance.
REQ-036 Mode 3, tx_data=8'hF0, slave model returning 8'h81 -> sclk idles high; 8 full sclk periods; rx_data=8'h81.
REQ-037 Mode 1 and mode 2, CLK_DIV=1, tx_data=8'h5A looped back (miso=mosi) -> rx_data=8'h5A; done 17 edges after acceptance.
REQ-038 start pulsed 5 cycles into a transfer with a different tx_data -> ignored; exactly one done pulse; transmitted byte is unchanged.
REQ-039 reset asserted mid-transfer after toggle 7 -> cs=1, sclk=0, busy=0 immediately; no done pulse; a following 8'hC3 transfer completes correctly.
REQ-040 start held high through the done cycle -> second transfer accepted on the done edge; cs high for exactly one cycle between transfers.

Source files
------------

// File: rtl/spi_master.sv
// Single-byte SPI master supporting modes 0-3 with a programmable sclk half-period.
// All outputs come straight from flops; sclk idles at CPOL and returns there after 16 toggles.
module spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] tx_data,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data
);

  localparam logic [7:0] DivReload = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StTransfer, StHold} state_e;

  state_e     r_state;
  logic [7:0] r_cnt;
  logic [4:0] r_tog;
  logic       r_cpha;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_cs;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_rx_data;

  logic       w_tick;
  logic [4:0] w_tog_next;
  logic       w_sample;

  assign w_tick     = (r_cnt == 8'd0);
  assign w_tog_next = r_tog + 5'd1;
  // Odd toggles are leading edges; CPHA selects whether leading edges sample or drive.
  assign w_sample   = w_tog_next[0] ^ r_cpha;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= 8'd0;
      r_tog     <= 5'd0;
      r_cpha    <= 1'b0;
      r_tx      <= 8'h00;
      r_rx      <= 8'h00;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= 8'h00;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_sclk <= mode[1];
          if (start) begin
            r_state <= StSetup;
            r_cpha  <= mode[0];
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= DivReload;
            r_tog   <= 5'd0;
            r_rx    <= 8'h00;
            if (!mode[0]) begin
              r_mosi <= tx_data[7];
              r_tx   <= {tx_data[6:0], 1'b0};
            end else begin
              r_tx   <= tx_data;
            end
          end
        end
        StSetup, StTransfer: begin
          if (w_tick) begin
            r_cnt  <= DivReload;
            r_tog  <= w_tog_next;
            r_sclk <= ~r_sclk;
            if (w_sample) begin
              r_rx <= {r_rx[6:0], miso};
            end else if (w_tog_next != 5'd16) begin
              r_mosi <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
            r_state <= (w_tog_next == 5'd16) ? StHold : StTransfer;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StHold: begin
          if (w_tick) begin
            r_state   <= StIdle;
            r_cs      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign cs      = r_cs;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule
